bcd_down_timer: RTL
===================

Name: bcd_down_timer

Overview:
- Loadable multi-digit BCD down-counter (countdown timer). It is the count-down counterpart to the team's decade up-counter.
- Sits beside the up-counter in the timing/display path. It takes a preset BCD value and decrements once per qualified tick.
- Flags completion with a single-cycle done pulse and holds at zero afterwards.

Parameters:
- DIGITS, 2, number of cascaded BCD digits. Count width is 4*DIGITS.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- load, input, 1, synchronous preset strobe.
- load_val, input, 4*DIGITS, BCD preset value; digit 0 is bits [3:0].
- start, input, 1, start or resume the countdown.
- pause, input, 1, freeze the countdown.
- tick, input, 1, decrement qualifier; one decrement per cycle with tick=1 while running.
- count, output, 4*DIGITS, current BCD value.
- running, output, 1, high while in RUN.
- done, output, 1, one-cycle pulse when the count reaches zero.

Behaviour:
- Reset (reset=0, asynchronous): count=0, state=IDLE, running=0, done=0. On release, the first active edge proceeds normally.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Input priority in every state: load > pause > start > tick.
- load (any state, including RUN):
  - count <= load_val, with each digit >9 clamped to 9.
  - state -> IDLE; done=0.
- IDLE:
  - start with count!=0 -> RUN.
  - start with count==0 -> DONE, with done=1 for one cycle on that transition.
- RUN:
  - pause -> PAUSE; count holds, and a tick in the same cycle is ignored.
  - tick=1 decrements count by 1 in BCD. The new value is visible one cycle after the sampling edge.
  - When the decrement produces 0 (count was 0…01): state -> DONE, done=1 on that same cycle, running=0.
  - start while in RUN has no effect.
- PAUSE:
  - start -> RUN; count unchanged. Ticks are counted from the next cycle.
  - tick is ignored.
- DONE:
  - count holds 0; done returns to 0 after one cycle.
  - start re-enters DONE handling: another one-cycle done pulse, no wrap.
  - Only load leaves DONE with a nonzero value.
- BCD decrement rule:
  - Each digit 0 -> 9 with a borrow out; otherwise digit-1 with no borrow.
  - Borrow ripples from digit 0 upward within one cycle (combinational chain, registered result).
  - Example: 0x10 -> 0x09, 0x100 -> 0x099.
  - The counter never wraps below 0. Underflow is impossible because the DONE transition occurs at zero.
- running = (state==RUN). done is asserted only on entry to DONE.
- Reset mid-operation forces the reset values immediately and needs no clock.

Decomposition:
- Shared package/header bcd_timer_defs:
  - State encodings: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11.
  - BCD_MAX = 4'd9.
- Sub-module bcd_digit_dec:
  - Pure combinational single-digit decrement.
  - Ports: digit_in[3:0], borrow_in, digit_out[3:0], borrow_out.
  - Includes the >9 clamp on load.
  - The top generates DIGITS instances chained on borrow.
- The top holds the FSM and the count register.

Test Plan:
- Reset: drive reset=0 mid-run with count=0x37 -> count=0x00, running=0, done=0 immediately, before any clk edge.
- Basic countdown: load 0x03, start, tick held 1 -> count 0x02, 0x01, 0x00 on consecutive cycles; done=1 exactly on the 0x00 cycle, then 0; count stays 0x00.
- Digit borrow: load 0x10, start, one tick -> 0x09. Load 0x00 with DIGITS=3 value 0x100, one tick -> 0x099.
- Pause/resume: load 0x25, start, 2 ticks -> 0x23; pause with tick=1 for 5 cycles -> holds 0x23; start -> next tick gives 0x22.
- Priority/edge: load 0x05 together with pause and start in RUN -> count=0x05, state IDLE, running=0. Load 0xAF -> count=0x99 (clamp). Start with count 0x00 -> done pulse one cycle, no wrap to 0x99.
- Tick gating: in RUN with tick toggling 1,0,0,1 from 0x09 -> 0x08, 0x08, 0x08, 0x07.

Source files
------------

// File: rtl/bcd_down_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding and digit limits.
package bcd_timer_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_down_timer_digit_dec.sv
// Single BCD digit decrement stage; with borrow_in low it passes the digit through clamped to 9.
module bcd_digit_dec
    import bcd_timer_defs::*;
(
    input  logic [3:0] digit_in,
    input  logic       borrow_in,
    output logic [3:0] digit_out,
    output logic       borrow_out
);

    logic [3:0] clamped;

    always_comb begin
        clamped    = (digit_in > BCD_MAX) ? BCD_MAX : digit_in;
        digit_out  = clamped;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (clamped == 4'd0) begin
                digit_out  = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_out = clamped - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer with start/pause control and a one-cycle done pulse.
module bcd_down_timer
    import bcd_timer_defs::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           done_q, done_d;

    logic [W-1:0]   chain_in;
    logic [W-1:0]   chain_out;
    logic [DIGITS:0] borrow;

    // One digit chain serves both paths: load clamps with no borrow, otherwise it decrements.
    assign chain_in  = load ? load_val : count_q;
    assign borrow[0] = ~load;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_dec u_digit (
            .digit_in   (chain_in[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .digit_out  (chain_out[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = chain_out;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!pause && start) begin
                        if (count_q == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick && !borrow[DIGITS]) begin
                        // A borrow out of the top digit would mean underflow; never wrap.
                        count_d = chain_out;
                        if (chain_out == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (!pause && start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (!pause && start) begin
                        done_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count   = count_q;
    assign running = (state_q == RUN);
    assign done    = done_q;

endmodule
